// File: rtl/rl7_decoder.sv
// rtl/rl7_decoder.sv - run-length (RL7) / CLUT8 pass-through line pixel decoder
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   st             line length select: 1 = 360 pixels, 0 = 384 pixels
//   hsync          single-cycle line start: clears the pixel counter, restarts decode
//   rl_enable      1 = RL7 decode, 0 = byte pass-through; sampled at hsync/reset only
//   in_write       upstream byte valid
//   in_pixel[7:0]  upstream byte
//   in_strobe      decoder ready for an upstream byte
//   out_write      decoded pixel valid
//   out_pixel[7:0] decoded pixel index
//   out_strobe     sink ready for a pixel
//
// RL7 codes: 0ccccccc = one pixel of colour c; 1ccccccc,n = n pixels of colour c,
// with n = 0 meaning "fill to end of line". Output never runs past the line end.
module rl7_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       st,
    input  logic       hsync,
    input  logic       rl_enable,
    input  logic       in_write,
    input  logic [7:0] in_pixel,
    output logic       in_strobe,
    output logic       out_write,
    output logic [7:0] out_pixel,
    input  logic       out_strobe
);

    typedef enum logic [2:0] {
        S_CMD,
        S_COUNT,
        S_RUN,
        S_FILL,
        S_DONE
    } state_t;

    state_t     state;
    logic [8:0] count;
    logic [7:0] remaining;
    logic [6:0] color;
    logic       rl_mode;

    logic [8:0] line_len;
    logic       line_end;
    logic       last_pixel;
    logic       in_xfer;
    logic       out_xfer;

    assign line_len   = st ? 9'd360 : 9'd384;
    assign line_end   = (count >= line_len);
    // True when the pixel now on the bus is the final one of the line.
    assign last_pixel = ((count + 9'd1) >= line_len);
    assign in_xfer    = in_write && in_strobe;
    assign out_xfer   = out_write && out_strobe;

    // Handshakes in decode mode depend only on registered state and line_end,
    // so the upstream and sink handshakes never form a combinational loop.
    always_comb begin
        in_strobe = 1'b0;
        out_write = 1'b0;
        out_pixel = 8'h00;
        if (!reset) begin
            if (!rl_mode) begin
                in_strobe = out_strobe && !line_end;
                out_write = in_write && !line_end;
                out_pixel = in_pixel;
            end else begin
                out_pixel = {1'b0, color};
                case (state)
                    S_CMD:          in_strobe = !line_end;
                    S_COUNT:        in_strobe = 1'b1;
                    S_RUN, S_FILL:  out_write = !line_end;
                    default:        ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_CMD;
            count     <= 9'd0;
            remaining <= 8'd0;
            color     <= 7'd0;
            rl_mode   <= rl_enable;
        end else if (hsync) begin
            // Any transfer on the hsync cycle is dropped: the new line starts clean.
            state   <= S_CMD;
            count   <= 9'd0;
            rl_mode <= rl_enable;
        end else begin
            if (out_xfer) begin
                count <= count + 9'd1;
            end
            if (rl_mode) begin
                case (state)
                    S_CMD: begin
                        if (line_end) begin
                            state <= S_DONE;
                        end else if (in_xfer) begin
                            color <= in_pixel[6:0];
                            if (in_pixel[7]) begin
                                state <= S_COUNT;
                            end else begin
                                remaining <= 8'd1;
                                state     <= S_RUN;
                            end
                        end
                    end
                    S_COUNT: begin
                        if (in_xfer) begin
                            if (in_pixel == 8'd0) begin
                                state <= S_FILL;
                            end else begin
                                remaining <= in_pixel;
                                state     <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        if (line_end) begin
                            state <= S_DONE;
                        end else if (out_xfer) begin
                            remaining <= remaining - 8'd1;
                            // Line end wins over run end; leftover count is dropped.
                            if (last_pixel) begin
                                state <= S_DONE;
                            end else if (remaining == 8'd1) begin
                                state <= S_CMD;
                            end
                        end
                    end
                    S_FILL: begin
                        if (line_end || (out_xfer && last_pixel)) begin
                            state <= S_DONE;
                        end
                    end
                    S_DONE: ;
                    default: state <= S_CMD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rl7_decoder.sv
// tb/tb_rl7_decoder.sv - directed self-checking bench for rl7_decoder
module tb_rl7_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       st;
    logic       hsync;
    logic       rl_enable;
    logic       in_write;
    logic [7:0] in_pixel;
    logic       in_strobe;
    logic       out_write;
    logic [7:0] out_pixel;
    logic       out_strobe;

    logic [7:0] ibytes[$];
    logic [7:0] got[$];
    int         got_cyc[$];
    int         stall_bad;
    int         n_stall;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         bad;

    always #5 clk = ~clk;

    rl7_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .st         (st),
        .hsync      (hsync),
        .rl_enable  (rl_enable),
        .in_write   (in_write),
        .in_pixel   (in_pixel),
        .in_strobe  (in_strobe),
        .out_write  (out_write),
        .out_pixel  (out_pixel),
        .out_strobe (out_strobe)
    );

    task automatic check_eq(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, actual, actual, expected, expected);
        end
    endtask

    // Clock n cycles with the upstream byte queue and sink; toggle = ready on even cycles only.
    task automatic run_cycles(input int n, input bit toggle);
        bit acc;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_write   = (ibytes.size() > 0);
            in_pixel   = in_write ? ibytes[0] : 8'h00;
            out_strobe = toggle ? (i % 2 == 0) : 1'b1;
            #1;
            acc = in_write && in_strobe;
            if (out_write && out_strobe) begin
                got.push_back(out_pixel);
                got_cyc.push_back(i);
            end
            if (out_write && !out_strobe) begin
                n_stall++;
                if (got.size() > 0 && out_pixel != got[got.size()-1]) stall_bad++;
            end
            @(posedge clk);
            if (acc) void'(ibytes.pop_front());
        end
    endtask

    task automatic peek(input bit os);
        @(negedge clk);
        in_write   = (ibytes.size() > 0);
        in_pixel   = in_write ? ibytes[0] : 8'h00;
        out_strobe = os;
        #1;
    endtask

    task automatic quiet();
        in_write   = 1'b0;
        out_strobe = 1'b0;
    endtask

    task automatic pulse_hsync(input bit with_byte, input logic [7:0] b);
        @(negedge clk);
        hsync      = 1'b1;
        in_write   = with_byte;
        in_pixel   = b;
        out_strobe = 1'b1;
        @(posedge clk);
        #1;
        hsync      = 1'b0;
        quiet();
    endtask

    task automatic clear_log();
        got.delete();
        got_cyc.delete();
        stall_bad = 0;
        n_stall   = 0;
    endtask

    function automatic int count_not(input logic [7:0] v);
        int c = 0;
        foreach (got[k]) if (got[k] != v) c++;
        return c;
    endfunction

    initial begin
        reset = 1'b1; st = 1'b0; hsync = 1'b0; rl_enable = 1'b1;
        in_write = 1'b1; in_pixel = 8'h85; out_strobe = 1'b1;
        clear_log();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_in_strobe", in_strobe, 0);
        check_eq("reset_out_write", out_write, 0);
        check_eq("reset_out_pixel", out_pixel, 0);
        @(negedge clk);
        reset = 1'b0;
        quiet();
        peek(1'b1);
        check_eq("post_reset_cmd_in_strobe", in_strobe, 1);
        check_eq("post_reset_cmd_out_write", out_write, 0);
        quiet();

        // Single pixel then a run of 3, sink always ready
        clear_log();
        ibytes = '{8'h05, 8'h85, 8'h03};
        run_cycles(10, 1'b0);
        check_eq("basic_count", got.size(), 4);
        check_eq("basic_values", count_not(8'h05), 0);
        if (got_cyc.size() >= 2) begin
            check_eq("basic_single_latency", got_cyc[0], 1);
            check_eq("basic_run_latency", got_cyc[1], 4);
        end else check_eq("basic_latency_missing", got_cyc.size(), 2);
        peek(1'b1);
        check_eq("basic_end_cmd_in_strobe", in_strobe, 1);
        check_eq("basic_end_cmd_out_write", out_write, 0);
        quiet();

        // Run of 6 with sink toggling
        pulse_hsync(1'b0, 8'h00);
        clear_log();
        ibytes = '{8'h8F, 8'h06};
        run_cycles(16, 1'b1);
        check_eq("stall_count", got.size(), 6);
        check_eq("stall_values", count_not(8'h0F), 0);
        check_eq("stall_cycles", n_stall, 5);
        check_eq("stall_hold_pixel", stall_bad, 0);
        if (got_cyc.size() == 6) check_eq("stall_last_cycle", got_cyc[5], 12);

        // Fill to end of a 360-pixel line
        st = 1'b1;
        pulse_hsync(1'b0, 8'h00);
        clear_log();
        ibytes = '{8'h92, 8'h00};
        run_cycles(370, 1'b0);
        check_eq("fill360_count", got.size(), 360);
        check_eq("fill360_values", count_not(8'h12), 0);
        ibytes = '{8'h55};
        peek(1'b1);
        check_eq("fill360_done_in_strobe", in_strobe, 0);
        check_eq("fill360_done_out_write", out_write, 0);
        quiet();
        run_cycles(3, 1'b0);
        check_eq("fill360_byte_held", ibytes.size(), 1);
        ibytes.delete();

        // Run clipped at 384-pixel line end
        st = 1'b0;
        pulse_hsync(1'b0, 8'h00);
        clear_log();
        ibytes = '{8'h81, 8'hFF, 8'h81, 8'h7D, 8'h81, 8'h0A, 8'h05};
        run_cycles(400, 1'b0);
        check_eq("clip_count", got.size(), 384);
        check_eq("clip_values", count_not(8'h01), 0);
        if (got_cyc.size() == 384) begin
            check_eq("clip_first_of_last_run", got_cyc[380], 386);
            check_eq("clip_last_pixel", got_cyc[383], 389);
        end
        check_eq("clip_next_byte_kept", ibytes.size(), 1);
        peek(1'b1);
        check_eq("clip_done_in_strobe", in_strobe, 0);
        check_eq("clip_done_out_write", out_write, 0);
        quiet();
        ibytes.delete();

        // hsync mid-run, then hsync discarding an accepted byte
        pulse_hsync(1'b0, 8'h00);
        clear_log();
        ibytes = '{8'h81, 8'h64};
        run_cycles(52, 1'b0);
        check_eq("midrun_pixels_before_hsync", got.size(), 50);
        pulse_hsync(1'b0, 8'h00);
        peek(1'b1);
        check_eq("midrun_hsync_in_strobe", in_strobe, 1);
        check_eq("midrun_hsync_out_write", out_write, 0);
        quiet();
        pulse_hsync(1'b1, 8'h85);
        clear_log();
        ibytes = '{8'h92, 8'h00};
        run_cycles(395, 1'b0);
        check_eq("post_hsync_fill_count", got.size(), 384);
        check_eq("post_hsync_fill_values", count_not(8'h12), 0);
        if (got_cyc.size() > 0) check_eq("post_hsync_fill_latency", got_cyc[0], 2);

        // Reset aborts a run
        pulse_hsync(1'b0, 8'h00);
        clear_log();
        ibytes = '{8'h83, 8'h20};
        run_cycles(5, 1'b0);
        @(negedge clk);
        reset      = 1'b1;
        out_strobe = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrun_reset_in_strobe", in_strobe, 0);
        check_eq("midrun_reset_out_write", out_write, 0);
        check_eq("midrun_reset_out_pixel", out_pixel, 0);
        @(negedge clk);
        reset = 1'b0;
        quiet();
        ibytes.delete();
        peek(1'b1);
        check_eq("after_reset_in_strobe", in_strobe, 1);
        check_eq("after_reset_out_write", out_write, 0);
        quiet();

        // Mode change waits for hsync
        rl_enable = 1'b0;
        ibytes = '{8'h07};
        peek(1'b1);
        check_eq("mode_unlatched_out_write", out_write, 0);
        check_eq("mode_unlatched_in_strobe", in_strobe, 1);
        quiet();
        ibytes.delete();

        // Pass-through: 400 bytes offered, 384 forwarded
        pulse_hsync(1'b0, 8'h00);
        clear_log();
        for (int i = 0; i < 400; i++) ibytes.push_back(8'((i * 7 + 3) & 255));
        run_cycles(410, 1'b0);
        check_eq("pass_count", got.size(), 384);
        bad = 0;
        foreach (got[k]) if (got[k] != 8'((k * 7 + 3) & 255)) bad++;
        check_eq("pass_values", bad, 0);
        check_eq("pass_left_over", ibytes.size(), 16);
        peek(1'b1);
        check_eq("pass_end_in_strobe", in_strobe, 0);
        check_eq("pass_end_out_write", out_write, 0);
        quiet();
        pulse_hsync(1'b0, 8'h00);
        peek(1'b1);
        check_eq("pass_new_line_in_strobe", in_strobe, 1);
        check_eq("pass_new_line_out_write", out_write, 1);
        check_eq("pass_new_line_out_pixel", out_pixel, ibytes[0]);
        quiet();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
